// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: Funct3 codes, FSM encoding, byte-enable bases.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_t;

   // Encodings with no RV32I load/store meaning; they complete without touching the bus.
   function automatic logic f3_invalid(input logic [2:0] f3);
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store steering, load extract/extend, misalign detect.
// LSU_MISALIGN_TRAP_EN selects trapping versus silently aligning misaligned accesses.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  i_f3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [2:0]  i_ld_f3,
   input  logic [1:0]  i_ld_off,
   input  logic [31:0] i_rdata,
   output logic [1:0]  o_off,
   output logic        o_bad_f3,
   output logic        o_misalign,
   output logic [3:0]  o_st_be,
   output logic [31:0] o_st_wdata,
   output logic [31:0] o_ld_data
);

   logic       w_is_h;
   logic       w_is_w;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_is_h   = (i_f3[1:0] == 2'b01);
   assign w_is_w   = (i_f3[1:0] == 2'b10);
   assign o_bad_f3 = f3_invalid(i_f3);

`ifdef LSU_MISALIGN_TRAP_EN
   assign o_misalign = !o_bad_f3 && ((w_is_h && i_addr_lo[0]) || (w_is_w && (i_addr_lo != 2'b00)));
`else
   assign o_misalign = 1'b0;
`endif

   // Low address bits that would break width alignment are cleared.
   assign o_off = w_is_w ? 2'b00 : (w_is_h ? {i_addr_lo[1], 1'b0} : i_addr_lo);

   always_comb begin
      o_st_be    = BE_W;
      o_st_wdata = i_wdata;
      case (i_f3[1:0])
         2'b00: begin
            o_st_be    = 4'(BE_B << o_off);
            o_st_wdata = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            o_st_be    = 4'(BE_H << o_off);
            o_st_wdata = {2{i_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign w_byte = i_rdata[{i_ld_off, 3'b000} +: 8];
   assign w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];

   always_comb begin
      o_ld_data = i_rdata;
      case (i_ld_f3)
         F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
         F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
         F3_BU:   o_ld_data = {24'd0, w_byte};
         F3_HU:   o_ld_data = {16'd0, w_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_datamem.sv
// Load/store unit: one req/ack bus access per instruction with a BusAck timeout.
// LSU_MISALIGN_TRAP_EN (see lsu_align) turns misaligned accesses into MisalignExc completions.
module lsu_datamem
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT    = 256,
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemReq,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        Done,
   output logic        BusErr,
   output logic        MisalignExc,
   output logic        BusReq,
   output logic        BusWe,
   output logic [31:0] BusAddr,
   output logic [3:0]  BusBe,
   output logic [31:0] BusWdata,
   input  logic        BusAck,
   input  logic [31:0] BusRdata
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   lsu_state_t  r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic        r_busreq, w_busreq_nxt;
   logic        r_buswe, w_buswe_nxt;
   logic [31:0] r_busaddr, w_busaddr_nxt;
   logic [3:0]  r_busbe, w_busbe_nxt;
   logic [31:0] r_buswdata, w_buswdata_nxt;
   logic [2:0]  r_f3, w_f3_nxt;
   logic [1:0]  r_off, w_off_nxt;
   logic [31:0] r_rdata, w_rdata_nxt;
   logic        r_done, w_done_nxt;
   logic        r_buserr, w_buserr_nxt;
   logic        r_misal, w_misal_nxt;

   logic [1:0]  w_off;
   logic        w_bad_f3;
   logic        w_misal;
   logic [3:0]  w_st_be;
   logic [31:0] w_st_wdata;
   logic [31:0] w_ld_data;

   lsu_align u_align (
      .i_f3       (Funct3),
      .i_addr_lo  (ALUResult[1:0]),
      .i_wdata    (WriteData),
      .i_ld_f3    (r_f3),
      .i_ld_off   (r_off),
      .i_rdata    (BusRdata),
      .o_off      (w_off),
      .o_bad_f3   (w_bad_f3),
      .o_misalign (w_misal),
      .o_st_be    (w_st_be),
      .o_st_wdata (w_st_wdata),
      .o_ld_data  (w_ld_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_busreq   <= 1'b0;
         r_buswe    <= 1'b0;
         r_busaddr  <= RESET_ADDR;
         r_busbe    <= 4'b0000;
         r_buswdata <= 32'd0;
         r_f3       <= 3'b000;
         r_off      <= 2'b00;
         r_rdata    <= 32'd0;
         r_done     <= 1'b0;
         r_buserr   <= 1'b0;
         r_misal    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_busreq   <= w_busreq_nxt;
         r_buswe    <= w_buswe_nxt;
         r_busaddr  <= w_busaddr_nxt;
         r_busbe    <= w_busbe_nxt;
         r_buswdata <= w_buswdata_nxt;
         r_f3       <= w_f3_nxt;
         r_off      <= w_off_nxt;
         r_rdata    <= w_rdata_nxt;
         r_done     <= w_done_nxt;
         r_buserr   <= w_buserr_nxt;
         r_misal    <= w_misal_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_busreq_nxt   = r_busreq;
      w_buswe_nxt    = r_buswe;
      w_busaddr_nxt  = r_busaddr;
      w_busbe_nxt    = r_busbe;
      w_buswdata_nxt = r_buswdata;
      w_f3_nxt       = r_f3;
      w_off_nxt      = r_off;
      w_rdata_nxt    = r_rdata;
      w_done_nxt     = 1'b0;
      w_buserr_nxt   = 1'b0;
      w_misal_nxt    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (MemReq) begin
               if (w_bad_f3 || w_misal) begin
                  w_state_nxt = ST_DONE;
                  w_done_nxt  = 1'b1;
                  w_misal_nxt = w_misal;
                  w_rdata_nxt = 32'd0;
               end else begin
                  w_state_nxt    = ST_BUSY;
                  w_cnt_nxt      = '0;
                  w_busreq_nxt   = 1'b1;
                  w_buswe_nxt    = MemWrite;
                  w_busaddr_nxt  = {ALUResult[31:2], 2'b00};
                  w_busbe_nxt    = MemWrite ? w_st_be : BE_W;
                  w_buswdata_nxt = MemWrite ? w_st_wdata : 32'd0;
                  w_f3_nxt       = Funct3;
                  w_off_nxt      = w_off;
               end
            end
         end
         ST_BUSY: begin
            // BusAck takes priority over a timeout on the same cycle.
            if (BusAck || (r_cnt == CW'(TIMEOUT - 1))) begin
               w_state_nxt    = ST_DONE;
               w_done_nxt     = 1'b1;
               w_buserr_nxt   = !BusAck;
               w_rdata_nxt    = (BusAck && !r_buswe) ? w_ld_data : 32'd0;
               w_busreq_nxt   = 1'b0;
               w_buswe_nxt    = 1'b0;
               w_busaddr_nxt  = RESET_ADDR;
               w_busbe_nxt    = 4'b0000;
               w_buswdata_nxt = 32'd0;
            end else begin
               w_cnt_nxt = CW'(r_cnt + CW'(1));
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Stall is combinational in IDLE so the core freezes on the issue cycle itself.
   assign Stall = (r_state == ST_IDLE) ? MemReq : (r_state == ST_BUSY);

   assign ReadData    = r_rdata;
   assign Done        = r_done;
   assign BusErr      = r_buserr;
   assign MisalignExc = r_misal;
   assign BusReq      = r_busreq;
   assign BusWe       = r_buswe;
   assign BusAddr     = r_busaddr;
   assign BusBe       = r_busbe;
   assign BusWdata    = r_buswdata;

endmodule
